// File: rtl/ntt_mdc_seq.sv
// ntt_mdc_seq: sequencer wrapped around a multi-path delay-commutator NTT stage chain.
// Frames input beats into polynomials, launches them into the chain with a one-cycle
// registered latency, tracks how many polynomials are inside the chain, and replays
// each finished polynomial on the output port as BEATS consecutive beats.
// Optional feature: define NTT_MDC_SEQ_STATS_EN to get a wrapping count of emitted
// polynomials on poly_cnt; otherwise poly_cnt is tied to zero.
module ntt_mdc_seq #(
   parameter int unsigned LOGQ         = 32,
   parameter int unsigned LOGN         = 10,
   parameter int unsigned LANES        = 2,
   parameter int unsigned MAX_INFLIGHT = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode_in,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [LANES*LOGQ-1:0] s_data,
   input  logic                  s_last,
   output logic                  chain_start,
   output logic                  chain_intt,
   output logic [LANES*LOGQ-1:0] chain_din,
   input  logic                  chain_finish,
   input  logic [LANES*LOGQ-1:0] chain_dout,
   output logic                  m_valid,
   output logic [LANES*LOGQ-1:0] m_data,
   output logic                  m_last,
   output logic                  err_len,
   output logic                  err_ovr,
   input  logic                  clr_err,
   output logic                  busy,
   output logic [2:0]            inflight,
   output logic [31:0]           poly_cnt
);

   localparam int unsigned BEATS = (2 ** LOGN) / LANES;
   localparam int unsigned CW    = $clog2(BEATS + 1);

   localparam logic [CW-1:0] BEATS_C  = CW'(BEATS);
   localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [2:0]    MAX_C    = 3'(MAX_INFLIGHT);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StLoad = 2'd1;
   localparam logic [1:0] StHold = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CW-1:0]         beat_q, beat_d, beat_idx, beat_inc;
   logic                  mode_q, mode_d;
   logic                  rdy_en_q;
   logic                  start_q;
   logic [LANES*LOGQ-1:0] din_q, mdata_q;
   logic [2:0]            infl_q, infl_d, infl_pend;
   logic [CW-1:0]         out_cnt_q, out_cnt_d;
   logic                  err_len_q, err_ovr_q;
   logic                  idle, idle_ok, accept, beat_done, len_bad, fin_take, ovr_set;

   assign m_valid     = (out_cnt_q != '0);
   assign m_last      = (out_cnt_q == BEATS_C);
   assign chain_start = start_q;
   assign chain_intt  = mode_q;
   assign chain_din   = din_q;
   assign m_data      = mdata_q;
   assign err_len     = err_len_q;
   assign err_ovr     = err_ovr_q;
   assign inflight    = infl_q;
   assign busy        = (state_q != StIdle) || (infl_q != 3'd0) || m_valid;

   // Input handshake, beat indexing and framing check.
   always_comb begin
      idle      = (state_q == StIdle);
      // A launch still on chain_start counts as occupying the chain.
      infl_pend = infl_q + {2'b00, start_q};
      idle_ok   = (infl_pend < MAX_C) && ((infl_pend == 3'd0) || (mode_in == mode_q));
      s_ready   = rdy_en_q && (idle ? idle_ok : 1'b1);
      accept    = s_valid && s_ready;
      beat_idx  = idle ? '0 : beat_q;
      beat_inc  = beat_idx + ONE_C;
      beat_done = (beat_inc == BEATS_C);
      len_bad   = accept && (s_last != (beat_idx == LAST_IDX));
   end

   // Input FSM next state; a one-beat polynomial completes on acceptance and stays idle.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      mode_d  = mode_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               mode_d  = mode_in;
               beat_d  = beat_done ? '0 : beat_inc;
               state_d = beat_done ? StIdle : StLoad;
            end
         end
         StLoad, StHold: begin
            if (accept) begin
               beat_d  = beat_done ? '0 : beat_inc;
               state_d = beat_done ? StIdle : StLoad;
            end else if (state_q == StLoad) begin
               state_d = StHold;
            end
         end
         default: begin
            state_d = StIdle;
            beat_d  = '0;
         end
      endcase
   end

   // Output replay counter; a finish may overlap only the final beat of the previous run,
   // and only when some polynomial in the chain is not already being drained.
   always_comb begin
      fin_take  = chain_finish && (!m_valid || m_last) && (infl_q > {2'b00, m_valid});
      ovr_set   = chain_finish && !fin_take;
      out_cnt_d = '0;
      if (fin_take) begin
         out_cnt_d = ONE_C;
      end else if (m_valid && !m_last) begin
         out_cnt_d = out_cnt_q + ONE_C;
      end
   end

   // Occupancy: +1 on a launch, -1 on the final output beat, unchanged when both coincide.
   always_comb begin
      infl_d = infl_q;
      if (start_q && !m_last) begin
         infl_d = infl_q + 3'd1;
      end else if (!start_q && m_last && (infl_q != 3'd0)) begin
         infl_d = infl_q - 3'd1;
      end
   end

   // Input-side state: FSM, beat counter, mode, launch pulse and chain data register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         beat_q   <= '0;
         mode_q   <= 1'b0;
         rdy_en_q <= 1'b0;
         start_q  <= 1'b0;
         din_q    <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         mode_q   <= mode_d;
         rdy_en_q <= 1'b1;
         start_q  <= accept && idle;
         if (accept) begin
            din_q <= s_data;
         end
      end
   end

   // Output-side state: replay counter, output data register and occupancy count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_cnt_q <= '0;
         mdata_q   <= '0;
         infl_q    <= 3'd0;
      end else begin
         out_cnt_q <= out_cnt_d;
         infl_q    <= infl_d;
         if (out_cnt_d != '0) begin
            mdata_q <= chain_dout;
         end
      end
   end

   // Sticky error flags; a new error event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_len_q <= 1'b0;
         err_ovr_q <= 1'b0;
      end else begin
         err_len_q <= len_bad ? 1'b1 : (clr_err ? 1'b0 : err_len_q);
         err_ovr_q <= ovr_set ? 1'b1 : (clr_err ? 1'b0 : err_ovr_q);
      end
   end

`ifdef NTT_MDC_SEQ_STATS_EN
   logic [31:0] poly_cnt_q;

   // Count of emitted polynomials, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         poly_cnt_q <= 32'd0;
      end else if (m_last) begin
         poly_cnt_q <= poly_cnt_q + 32'd1;
      end
   end

   assign poly_cnt = poly_cnt_q;
`else
   assign poly_cnt = 32'd0;
`endif

endmodule
